// File: rtl/instruction_cache.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_cache
//  Purpose  : Direct-mapped, read-only instruction cache. Serves 32-bit words
//             from 128-bit lines. Hits return in the same cycle; misses stall
//             the CPU while the block is fetched from instruction memory.
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_cache #(
  parameter  int INDEX_BITS = 3,
  localparam int TAG_BITS   = 28 - INDEX_BITS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [31:0]  address,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [27:0]  mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [27:0]           mem_address_q, mem_address_d;
  logic                  seen_busy_q, seen_busy_d;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [127:0]          data_q [LINES];

  // Live CPU address fields
  logic [1:0]            w_offset;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [127:0]          w_line;
  logic                  w_hit;
  logic                  w_addr_unused;

  // Fill target comes from the captured block address, never the live PC
  logic [INDEX_BITS-1:0] w_fill_index;
  logic [TAG_BITS-1:0]   w_fill_tag;

  assign w_offset      = address[3:2];
  assign w_index       = address[3+INDEX_BITS:4];
  assign w_tag         = address[31:4+INDEX_BITS];
  assign w_addr_unused = ^address[1:0];

  assign w_fill_index  = mem_address_q[INDEX_BITS-1:0];
  assign w_fill_tag    = mem_address_q[27:INDEX_BITS];

  assign w_line = data_q[w_index];
  assign w_hit  = read && valid_q[w_index] && (tag_q[w_index] == w_tag)
                  && (state_q == S_IDLE);

  // Word select within the line; value is meaningless unless w_hit
  always_comb begin
    instruction = 32'd0;
    case (w_offset)
      2'b00:   instruction = w_line[31:0];
      2'b01:   instruction = w_line[63:32];
      2'b10:   instruction = w_line[95:64];
      default: instruction = w_line[127:96];
    endcase
  end

  // Stall whenever the request is unserved or a fill is in progress
  assign busywait    = !reset && ((read && !w_hit) || (state_q != S_IDLE));
  assign mem_read    = (state_q == S_MEM_READ);
  assign mem_address = mem_address_q;

  // Next-state logic: capture miss block, wait for a full busy pulse, fill
  always_comb begin
    state_d       = state_q;
    mem_address_d = mem_address_q;
    seen_busy_d   = seen_busy_q;
    case (state_q)
      S_IDLE: begin
        if (read && !w_hit) begin
          state_d       = S_MEM_READ;
          mem_address_d = address[31:4];
          seen_busy_d   = 1'b0;
        end
      end
      S_MEM_READ: begin
        seen_busy_d = seen_busy_q | mem_busywait;
        if (seen_busy_q && !mem_busywait) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and valid bits; reset abandons any in-flight fill
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mem_address_q <= 28'd0;
      seen_busy_q   <= 1'b0;
      valid_q       <= '0;
    end else begin
      state_q       <= state_d;
      mem_address_q <= mem_address_d;
      seen_busy_q   <= seen_busy_d;
      if (state_q == S_UPDATE) begin
        valid_q[w_fill_index] <= 1'b1;
      end
    end
  end

  // Tag and data storage; not reset since valid bits guard them
  always_ff @(posedge clock) begin
    if (state_q == S_UPDATE) begin
      tag_q[w_fill_index]  <= w_fill_tag;
      data_q[w_fill_index] <= mem_readdata;
    end
  end

endmodule
`default_nettype wire
